// File: rtl/imem_dmem_responder_if.sv
// Core-facing fetch/load-store bus plus the program-image load port.
// Latency: none; signal bundle only.
// Backpressure: ld_valid/ld_ready handshake on the load port; core port never stalls.
interface imem_dmem_responder_if;
  // core fetch port
  logic [31:0] inst_adr;
  logic [31:0] inst;
  // core data port
  logic [31:0] data_adr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_read;
  logic        mem_write;
  // program-image load port
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;

  // core / boot source side
  modport master (
    output inst_adr, data_adr, write_data, mem_read, mem_write,
    output ld_valid, ld_data, ld_last,
    input  inst, read_data, ld_ready
  );

  // memory responder side
  modport slave (
    input  inst_adr, data_adr, write_data, mem_read, mem_write,
    input  ld_valid, ld_data, ld_last,
    output inst, read_data, ld_ready
  );
endinterface

// File: rtl/imem_dmem_responder.sv
// Boots the core: loads imem from the load port, zero-clears dmem, then serves fetch/load/store.
// Latency: fetch and load are combinational; stores and image words commit at the accepting edge.
// Backpressure: ld_ready only while loading; the core is held in cpu_rst until boot completes.
module imem_dmem_responder #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  imem_dmem_responder_if.slave          bus,
  output logic                          cpu_rst,
  output logic [$clog2(IMEM_WORDS):0]   words_loaded,
  output logic                          err_misaligned,
  output logic                          err_range
);

  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IA-1:0] ld_ptr;
  logic [DA-1:0] clr_ptr;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  // word addresses; the byte-lane bits never select anything
  logic [29:0]   inst_word;
  logic [29:0]   data_word;
  logic [IA-1:0] inst_idx;
  logic [DA-1:0] data_idx;
  logic          inst_in_range;
  logic          data_in_range;
  logic          data_aligned;
  logic          unused_inst_lane;

  assign inst_word        = bus.inst_adr[31:2];
  assign data_word        = bus.data_adr[31:2];
  assign inst_idx         = inst_word[IA-1:0];
  assign data_idx         = data_word[DA-1:0];
  assign inst_in_range    = (inst_word < 30'(IMEM_WORDS));
  assign data_in_range    = (data_word < 30'(DMEM_WORDS));
  assign data_aligned     = (bus.data_adr[1:0] == 2'b00);
  assign unused_inst_lane = ^bus.inst_adr[1:0];

  // decoded per-cycle actions
  logic        ld_accept;
  logic        ld_rdy_int;
  logic        store_en;
  logic        set_mis;
  logic        set_rng;
  logic [31:0] inst_int;
  logic [31:0] rdata_int;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // next state, load handshake, core-port read muxes and error/store decode
  always_comb begin
    state_nxt  = state;
    ld_rdy_int = 1'b0;
    ld_accept  = 1'b0;
    store_en   = 1'b0;
    set_mis    = 1'b0;
    set_rng    = 1'b0;
    inst_int   = 32'h0;
    rdata_int  = 32'h0;

    case (state)
      LOAD: begin
        ld_rdy_int = !rst;
        ld_accept  = bus.ld_valid && !rst;
        // a full image ends the load even without ld_last
        if (ld_accept && (bus.ld_last || (ld_ptr == IA'(IMEM_WORDS - 1)))) begin
          state_nxt = CLEAR;
        end
      end

      CLEAR: begin
        if (clr_ptr == DA'(DMEM_WORDS - 1)) begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (inst_in_range) begin
          inst_int = imem[inst_idx];
        end else begin
          set_rng = 1'b1;
        end

        if (bus.mem_read) begin
          if (data_in_range) begin
            rdata_int = dmem[data_idx];
          end else begin
            set_rng = 1'b1;
          end
        end

        if (bus.mem_write) begin
          if (!data_aligned) begin
            set_mis = 1'b1;
          end
          if (!data_in_range) begin
            set_rng = 1'b1;
          end
          store_en = data_aligned && data_in_range && !rst;
        end
      end

      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  assign bus.ld_ready  = ld_rdy_int;
  assign bus.inst      = inst_int;
  assign bus.read_data = rdata_int;
  // rst reaches the core combinationally so a reset in RUN stops it at once
  assign cpu_rst       = (state != RUN) || rst;

  // load and clear pointers plus the accepted-word count
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_ptr       <= '0;
      clr_ptr      <= '0;
      words_loaded <= '0;
    end else begin
      if (ld_accept) begin
        ld_ptr       <= ld_ptr + 1'b1;
        words_loaded <= words_loaded + 1'b1;
      end
      // wraps back to zero on the final clear, ready for the next boot
      if (state == CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  // sticky error flags, only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      err_misaligned <= 1'b0;
      err_range      <= 1'b0;
    end else begin
      if (set_mis) begin
        err_misaligned <= 1'b1;
      end
      if (set_rng) begin
        err_range <= 1'b1;
      end
    end
  end

  // instruction memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (ld_accept) begin
      imem[ld_ptr] <= bus.ld_data;
    end
  end

  // data memory write port: boot-time zero sweep, otherwise core stores
  always_ff @(posedge clk) begin
    if ((state == CLEAR) && !rst) begin
      dmem[clr_ptr] <= 32'h0;
    end else if (store_en) begin
      dmem[data_idx] <= bus.write_data;
    end
  end

endmodule

// File: tb/tb_imem_dmem_responder.sv
// Self-checking bench for imem_dmem_responder with small memories.
// Randomized image, address and store traffic compared against an array model.
// Load-port gaps exercise the valid/ready handshake.
module tb_imem_dmem_responder;

  localparam int IW = 8;
  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_rst;
  logic [3:0] words_loaded;
  logic       err_misaligned;
  logic       err_range;

  always #5 clk = ~clk;

  imem_dmem_responder_if bus ();

  imem_dmem_responder #(
    .IMEM_WORDS(IW),
    .DMEM_WORDS(DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .cpu_rst       (cpu_rst),
    .words_loaded  (words_loaded),
    .err_misaligned(err_misaligned),
    .err_range     (err_range)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] m_imem [IW];
  logic [31:0] m_dmem [DW];
  bit          m_mis;
  bit          m_rng;
  logic [31:0] img [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_adr   = 32'h0;
    bus.data_adr   = 32'h0;
    bus.write_data = 32'h0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = 32'h0;
    bus.ld_last    = 1'b0;
  endtask

  function automatic logic [31:0] model_inst();
    logic [31:0] w;
    w = bus.inst_adr >> 2;
    return (w < IW) ? m_imem[w] : 32'h0;
  endfunction

  function automatic logic [31:0] model_read();
    logic [31:0] w;
    w = bus.data_adr >> 2;
    return (bus.mem_read && (w < DW)) ? m_dmem[w] : 32'h0;
  endfunction

  // what one RUN-phase clock edge does to the model
  function automatic void model_edge();
    logic [31:0] iw;
    logic [31:0] dw;
    iw = bus.inst_adr >> 2;
    dw = bus.data_adr >> 2;
    if (iw >= IW) m_rng = 1'b1;
    if (bus.mem_read && (dw >= DW)) m_rng = 1'b1;
    if (bus.mem_write) begin
      if (bus.data_adr[1:0] != 2'b00) m_mis = 1'b1;
      if (dw >= DW) m_rng = 1'b1;
      if ((bus.data_adr[1:0] == 2'b00) && (dw < DW)) m_dmem[dw] = bus.write_data;
    end
  endfunction

  task automatic run_edge();
    model_edge();
    step();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_mis = 1'b0;
    m_rng = 1'b0;
  endtask

  // streams img[] into the load port, then checks the boot timing
  task automatic load_image(input bit use_last, input bit gaps, input bit extra);
    int  acc;
    int  cyc;
    bit  done;
    acc  = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && (cyc < 200)) begin
      bus.ld_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.ld_data  = img[acc];
      bus.ld_last  = use_last && (acc == img.size() - 1);
      #1;
      checks++;
      if (bus.ld_ready !== 1'b1) begin
        errors++;
        $display("FAIL ld_ready_loading: got %b expected 1 (word %0d)", bus.ld_ready, acc);
      end
      if (bus.ld_valid) begin
        m_imem[acc] = img[acc];
        acc++;
        if (bus.ld_last || (acc == IW)) done = 1'b1;
      end
      step();
      cyc++;
    end
    if (!done) begin
      errors++;
      $display("FAIL load_timeout: accepted %0d of %0d words", acc, img.size());
    end
    bus.ld_valid = extra;
    bus.ld_data  = 32'hBAD0BAD0;
    bus.ld_last  = 1'b0;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL ld_ready_drop: got %b expected 0", bus.ld_ready);
    end
    checks++;
    if (words_loaded !== 4'(acc)) begin
      errors++;
      $display("FAIL words_loaded: got %0d expected %0d", words_loaded, acc);
    end
    for (int i = 0; i < DW; i++) begin
      checks++;
      if (cpu_rst !== 1'b1) begin
        errors++;
        $display("FAIL cpu_rst_during_clear: got %b expected 1 at clear cycle %0d", cpu_rst, i);
      end
      step();
    end
    checks++;
    if (cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rst_release: got %b expected 0", cpu_rst);
    end
    checks++;
    if (words_loaded !== 4'(acc)) begin
      errors++;
      $display("FAIL words_after_boot: got %0d expected %0d", words_loaded, acc);
    end
    bus.ld_valid = 1'b0;
    for (int i = 0; i < DW; i++) m_dmem[i] = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (cpu_rst !== 1'b1 || bus.ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got cpu_rst=%b ld_ready=%b expected 1/0", cpu_rst, bus.ld_ready);
    end
    checks++;
    if (words_loaded !== 4'd0 || err_misaligned !== 1'b0 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got words=%0d mis=%b rng=%b expected 0/0/0",
               words_loaded, err_misaligned, err_range);
    end
    rst   = 1'b0;
    m_mis = 1'b0;
    m_rng = 1'b0;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got ld_ready=%b cpu_rst=%b expected 1/1", bus.ld_ready, cpu_rst);
    end
  endtask

  task automatic test_boot();
    img = '{32'h11, 32'h22, 32'h33};
    load_image(1'b1, 1'b0, 1'b0);
    bus.inst_adr = 32'h8;
    bus.mem_read = 1'b1;
    bus.data_adr = 32'h8;
    #1;
    checks++;
    if (bus.inst !== 32'h33) begin
      errors++;
      $display("FAIL boot_fetch: got %h expected 00000033", bus.inst);
    end
    checks++;
    if (bus.read_data !== 32'h0) begin
      errors++;
      $display("FAIL boot_dmem_zero: got %h expected 00000000", bus.read_data);
    end
    run_edge();
    idle_inputs();
  endtask

  task automatic test_gapped_and_full();
    do_reset();
    img = {};
    for (int i = 0; i < 5; i++) img.push_back($urandom);
    load_image(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.inst_adr = {$urandom_range(0, 4), 2'(($urandom_range(0, 3)))};
      #1;
      checks++;
      if (bus.inst !== model_inst()) begin
        errors++;
        $display("FAIL gapped_fetch: adr %h got %h expected %h", bus.inst_adr, bus.inst, model_inst());
      end
      run_edge();
    end
    do_reset();
    img = {};
    for (int i = 0; i < IW; i++) img.push_back($urandom);
    load_image(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < IW; i++) begin
      bus.inst_adr = 32'(i * 4);
      #1;
      checks++;
      if (bus.inst !== model_inst()) begin
        errors++;
        $display("FAIL full_fetch: word %0d got %h expected %h", i, bus.inst, model_inst());
      end
      run_edge();
    end
    idle_inputs();
  endtask

  task automatic test_store_load();
    logic [31:0] w;
    bus.mem_write  = 1'b1;
    bus.data_adr   = 32'h4;
    bus.write_data = 32'hDEADBEEF;
    run_edge();
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b1;
    #1;
    checks++;
    if (bus.read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_load: got %h expected deadbeef", bus.read_data);
    end
    run_edge();
    // same-word read and write: old data now, new data next cycle
    w = $urandom | 32'h1;
    bus.data_adr   = 32'hC;
    bus.mem_write  = 1'b1;
    bus.write_data = w;
    #1;
    checks++;
    if (bus.read_data !== 32'h0) begin
      errors++;
      $display("FAIL rw_same_cycle: got %h expected 00000000", bus.read_data);
    end
    run_edge();
    bus.mem_write = 1'b0;
    #1;
    checks++;
    if (bus.read_data !== w) begin
      errors++;
      $display("FAIL rw_next_cycle: got %h expected %h", bus.read_data, w);
    end
    run_edge();
    for (int i = 0; i < 16; i++) begin
      bus.data_adr   = {$urandom_range(0, DW - 1), 2'b00};
      bus.mem_read   = $urandom_range(0, 1) == 1;
      bus.mem_write  = $urandom_range(0, 1) == 1;
      bus.write_data = $urandom;
      #1;
      checks++;
      if (bus.read_data !== model_read()) begin
        errors++;
        $display("FAIL random_rw: adr %h got %h expected %h", bus.data_adr, bus.read_data, model_read());
      end
      run_edge();
    end
    idle_inputs();
    checks++;
    if (err_misaligned !== m_mis || err_range !== m_rng) begin
      errors++;
      $display("FAIL clean_flags: got mis=%b rng=%b expected %b/%b", err_misaligned, err_range, m_mis, m_rng);
    end
  endtask

  task automatic test_errors();
    bus.mem_write  = 1'b1;
    bus.data_adr   = 32'h6;
    bus.write_data = 32'h12345678;
    run_edge();
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b1;
    bus.data_adr   = 32'h4;
    #1;
    checks++;
    if (bus.read_data !== model_read()) begin
      errors++;
      $display("FAIL misaligned_no_write: got %h expected %h", bus.read_data, model_read());
    end
    checks++;
    if (err_misaligned !== 1'b1 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_flag: got mis=%b rng=%b expected 1/0", err_misaligned, err_range);
    end
    bus.mem_read = 1'b0;
    bus.inst_adr = 32'h20;
    #1;
    checks++;
    if (bus.inst !== 32'h0) begin
      errors++;
      $display("FAIL fetch_range_nop: got %h expected 00000000", bus.inst);
    end
    run_edge();
    bus.inst_adr = 32'h0;
    #1;
    checks++;
    if (err_range !== 1'b1) begin
      errors++;
      $display("FAIL fetch_range_flag: got %b expected 1", err_range);
    end
    for (int i = 0; i < 5; i++) run_edge();
    checks++;
    if (err_misaligned !== 1'b1 || err_range !== 1'b1) begin
      errors++;
      $display("FAIL flags_sticky: got mis=%b rng=%b expected 1/1", err_misaligned, err_range);
    end
    do_reset();
    checks++;
    if (err_misaligned !== 1'b0 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL flags_cleared: got mis=%b rng=%b expected 0/0", err_misaligned, err_range);
    end
    img = '{$urandom, $urandom};
    load_image(1'b1, 1'b0, 1'b0);
    bus.mem_read = 1'b1;
    bus.data_adr = 32'h10;
    #1;
    checks++;
    if (bus.read_data !== 32'h0) begin
      errors++;
      $display("FAIL load_range_zero: got %h expected 00000000", bus.read_data);
    end
    run_edge();
    bus.mem_read = 1'b0;
    for (int i = 0; i < 3; i++) run_edge();
    checks++;
    if (err_range !== 1'b1 || err_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL load_range_flag: got rng=%b mis=%b expected 1/0", err_range, err_misaligned);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hA0 + 32'(i);
      bus.ld_last  = (i == 2);
      m_imem[i]    = 32'hA0 + 32'(i);
      step();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear_cpu_rst: got %b expected 1", cpu_rst);
    end
    step();
    rst   = 1'b0;
    m_mis = 1'b0;
    m_rng = 1'b0;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b1 || cpu_rst !== 1'b1 || words_loaded !== 4'd0) begin
      errors++;
      $display("FAIL mid_clear_restart: got ld_ready=%b cpu_rst=%b words=%0d expected 1/1/0",
               bus.ld_ready, cpu_rst, words_loaded);
    end
    img = '{32'hB0, 32'hB1};
    load_image(1'b1, 1'b0, 1'b0);
    bus.inst_adr = 32'h8;
    #1;
    checks++;
    if (bus.inst !== 32'hA2) begin
      errors++;
      $display("FAIL old_imem_kept: got %h expected 000000a2", bus.inst);
    end
    bus.inst_adr = 32'h4;
    #1;
    checks++;
    if (bus.inst !== 32'hB1) begin
      errors++;
      $display("FAIL new_imem_word: got %h expected 000000b1", bus.inst);
    end
    run_edge();
    idle_inputs();
  endtask

  task automatic test_reset_in_run();
    bus.mem_write  = 1'b1;
    bus.data_adr   = 32'h4;
    bus.write_data = 32'hCAFEF00D;
    run_edge();
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b1;
    #1;
    checks++;
    if (bus.read_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL run_store: got %h expected cafef00d", bus.read_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL run_reset_same_cycle: got %b expected 1", cpu_rst);
    end
    step();
    rst   = 1'b0;
    m_mis = 1'b0;
    m_rng = 1'b0;
    idle_inputs();
    img = '{$urandom};
    load_image(1'b1, 1'b0, 1'b0);
    bus.mem_read = 1'b1;
    bus.data_adr = 32'h4;
    #1;
    checks++;
    if (bus.read_data !== 32'h0) begin
      errors++;
      $display("FAIL reboot_dmem_cleared: got %h expected 00000000", bus.read_data);
    end
    run_edge();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_boot();
    test_gapped_and_full();
    test_store_load();
    test_errors();
    test_reset_mid_clear();
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_dmem_responder.md
# imem_dmem_responder

Memory-side responder for the five-stage pipeline core: serves the core's instruction-fetch port and its data load/store port from two on-chip word arrays. After reset it runs a boot sequence, then releases the core:
- Streams a program image into instruction memory over a valid/ready load port.
- Zero-clears data memory.
- Deasserts `cpu_rst` to start the core.

Sits beside the pipeline top in the system wrapper; the testbench or boot source drives the load port.

## Interface

- `IMEM_WORDS`, 256: instruction memory depth in 32-bit words (power of 2, ≥ 2).
- `DMEM_WORDS`, 256: data memory depth in 32-bit words (power of 2, ≥ 2).

Ports (one clock; reset is synchronous and active-high):

- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `inst_adr` in 32: byte address of the fetch.
- `inst` out 32: fetched instruction.
- `data_adr` in 32: byte address of the load/store.
- `write_data` in 32: store data from the core.
- `read_data` out 32: load data to the core.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `ld_valid` in 1: load-port word valid.
- `ld_data` in 32: program word.
- `ld_last` in 1: marks the final program word.
- `ld_ready` out 1: responder accepts a load word.
- `cpu_rst` out 1: reset to the core; high until boot completes.
- `words_loaded` out clog2(IMEM_WORDS)+1: count of accepted program words.
- `err_misaligned` out 1: sticky; a store had `data_adr[1:0]`≠0.
- `err_range` out 1: sticky; an access fell beyond its array.

## Operation

State machine states are LOAD, CLEAR and RUN.

- **Reset:** `rst`=1 at an edge sets the following:
  - state←LOAD
  - `ld_ptr`←0, `clr_ptr`←0
  - `words_loaded`←0
  - `err_misaligned`←0, `err_range`←0
- **Memory contents at reset:** imem contents are not reset. dmem is overwritten by CLEAR.
- **Combinational outputs:**
  - `ld_ready` = (state==LOAD) & !`rst`.
  - `cpu_rst` = (state!=RUN) | `rst`.
- **LOAD:** accept = `ld_valid` & `ld_ready`. Each accept does the following:
  - Writes imem[`ld_ptr`]←`ld_data`.
  - Increments `ld_ptr` and `words_loaded`.
  - Moves to CLEAR if `ld_last`=1 or `ld_ptr`==IMEM_WORDS-1 (a full image auto-terminates; further words are never accepted).
- **CLEAR:**
  - Each cycle writes dmem[`clr_ptr`]←0 and increments `clr_ptr`.
  - The write with `clr_ptr`==DMEM_WORDS-1 moves the state to RUN.
  - Core port requests are ignored during CLEAR.
- **RUN, fetch:**
  - If `inst_adr[31:2]` < IMEM_WORDS: `inst` = imem[`inst_adr[31:2]`], combinational.
  - Otherwise `inst`=32'h0 (nop) and `err_range` is set at the next edge.
  - `inst_adr[1:0]` is ignored.
- **RUN, load:**
  - `read_data` = dmem[`data_adr[31:2]`], combinational, when `mem_read`=1 and in range.
  - Otherwise `read_data`=0.
  - An out-of-range load sets `err_range`.
- **RUN, store:** on an edge with `mem_write`=1, dmem[`data_adr[31:2]`]←`write_data`, except:
  - If `data_adr[1:0]`≠0: the write is suppressed and `err_misaligned` is set.
  - If out of range: the write is suppressed and `err_range` is set.
- **Simultaneous load and store** to the same word: `read_data` shows the old value in that cycle and the new value from the next cycle.
- **Outside RUN:**
  - `inst`=0 and `read_data`=0.
  - `mem_write` has no effect.
  - Error flags do not update.
- **Sticky flags:** cleared only by `rst`.

## Timing

- Reads are zero-latency (combinational); stores commit at the request edge.
- First accept is possible in the first cycle after `rst` deasserts.
- If the last word is accepted at edge k:
  - CLEAR occupies cycles k+1 … k+DMEM_WORDS.
  - `cpu_rst` falls in the cycle following edge k+DMEM_WORDS.
- `ld_ready` drops in the cycle after the terminating accept.
- `rst` mid-LOAD or mid-CLEAR: the next cycle is LOAD with pointers at 0, and previously loaded imem words remain but are overwritten by the new image.
- `rst` in RUN: `cpu_rst` rises combinationally in the same cycle, and the boot sequence repeats.

## Test plan

Bench parameters are IMEM_WORDS=8 and DMEM_WORDS=4.

1. **Boot:** load words 0x11,0x22,0x33 with `ld_last` on 0x33, `ld_valid` held high continuously.
   - `words_loaded`=3.
   - `ld_ready` low after the third accept.
   - `cpu_rst` low exactly 4 cycles after that edge.
   - `inst_adr`=8 returns 0x33.
2. **Backpressure/gaps and full image:**
   - Gapped `ld_valid` loads only on valid cycles.
   - 8 words without `ld_last` auto-terminate with `words_loaded`=8; a 9th valid is not accepted.
3. **Store/load:**
   - Store 0xDEADBEEF at 0x4, then load 0x4 → 0xDEADBEEF.
   - Load 0x8 right after boot → 0.
   - Simultaneous read+write of 0xC: `read_data`=0 in the same cycle, new value in the next.
4. **Errors:**
   - Store at 0x6 → dmem unchanged, `err_misaligned`=1.
   - Load at 0x10 → `read_data`=0, `err_range`=1.
   - Fetch at 0x20 → `inst`=0, `err_range`=1.
   - Both flags hold until `rst`.
5. **Reset mid-CLEAR:** assert `rst` during CLEAR.
   - `cpu_rst` stays high and `ld_ready` returns high.
   - Reload of 2 words gives `words_loaded`=2.
   - The old imem word 2 persists.
6. **Reset in RUN:** assert `rst` in RUN.
   - `cpu_rst` rises the same cycle.
   - The earlier store to 0x4 reads back 0 after the re-boot.
